// File: rtl/alu_apb_slave_if.sv
// APB bus bundle between a master and the ALU register slave.
// The master drives the request signals. The slave drives the read data and the response.
interface alu_apb_slave_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/alu_apb_slave.sv
// Memory-mapped ALU on APB: operand/control registers plus a compute engine.
// The engine uses a single-cycle datapath for ops 0-6 and a 32-step shift-add loop for MUL.
module alu_apb_slave #(
    parameter int STALL_LIMIT = 40
) (
    input  logic          clk,
    input  logic          reset,
    alu_apb_slave_if.slave apb
);
    typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} apb_state_t;
    typedef enum logic [1:0] {E_IDLE, E_RUN, E_DONE}     eng_state_t;

    localparam int             SW        = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0]  STALL_MAX = SW'(STALL_LIMIT);

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_MUL = 3'd7;

    apb_state_t    r_apb_state, w_apb_next;
    eng_state_t    r_eng_state, w_eng_next;

    logic [31:0]   r_opa, r_opb, r_a, r_b;
    logic [2:0]    r_op, r_eop;
    logic [63:0]   r_prod, r_res;
    logic [5:0]    r_cnt;
    logic          r_carry, r_zero;
    logic [SW-1:0] r_stall;

    logic [2:0]    w_idx;
    logic          w_addr_ok, w_is_res, w_access;
    logic          w_pready, w_err, w_wr, w_start, w_finish;
    logic          w_busy, w_done, w_is_arith;
    logic [31:0]   w_rdata;
    logic [32:0]   w_sum, w_diff, w_step_sum;
    logic [63:0]   w_alu_res;
    logic          w_unused;

    // Byte-lane bits of the address carry no meaning for word registers.
    assign w_unused  = ^apb.paddr[1:0];

    assign w_idx     = apb.paddr[4:2];
    assign w_addr_ok = (apb.paddr[31:5] == 27'd0) && (w_idx <= 3'd5);
    assign w_is_res  = (w_idx == 3'd4) || (w_idx == 3'd5);
    assign w_access  = apb.psel && apb.penable && (r_apb_state != A_IDLE);

    assign w_wr      = w_pready && apb.pwrite && !w_err;
    assign w_start   = w_wr && (w_idx == 3'd2) && apb.pwdata[8];
    assign w_finish  = (r_eng_state == E_RUN) && ((r_eop != OP_MUL) || (r_cnt == 6'd32));

    // ---------------- APB FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_apb_state <= A_IDLE;
        else       r_apb_state <= w_apb_next;
    end

    always_comb begin
        // NOTE: defaulting every comb output first keeps paths that miss a branch from inferring latches.
        w_apb_next = r_apb_state;
        case (r_apb_state)
            A_IDLE:   if (apb.psel && !apb.penable) w_apb_next = A_SETUP;
            A_SETUP: begin
                if (apb.psel && apb.penable) w_apb_next = w_pready ? A_IDLE : A_ACCESS;
                else if (!apb.psel)          w_apb_next = A_IDLE;
            end
            A_ACCESS: begin
                if (!(apb.psel && apb.penable) || w_pready) w_apb_next = A_IDLE;
            end
            default:  w_apb_next = A_IDLE;
        endcase
    end

    always_comb begin
        w_pready = 1'b0;
        w_err    = 1'b0;
        if (w_access) begin
            if (!w_addr_ok || (apb.pwrite && (w_idx >= 3'd3)) || (apb.pwrite && w_busy)) begin
                w_pready = 1'b1;
                w_err    = 1'b1;
            end else if (!apb.pwrite && w_is_res && w_busy) begin
                if (r_stall == STALL_MAX) begin
                    w_pready = 1'b1;
                    w_err    = 1'b1;
                end
            end else begin
                w_pready = 1'b1;
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (w_idx)
            3'd0:    w_rdata = r_opa;
            3'd1:    w_rdata = r_opb;
            3'd2:    w_rdata = {29'd0, r_op};
            3'd3:    w_rdata = {28'd0, r_zero, r_carry, w_done, w_busy};
            3'd4:    w_rdata = r_res[31:0];
            3'd5:    w_rdata = r_res[63:32];
            default: w_rdata = 32'd0;
        endcase
    end

    assign apb.pready  = w_pready;
    assign apb.pslverr = w_err;
    assign apb.prdata  = (w_pready && !apb.pwrite && !w_err) ? w_rdata : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       r_stall <= '0;
        else if (w_access && !w_pready)  r_stall <= r_stall + 1'b1;
        else                             r_stall <= '0;
    end

    // ---------------- Register file ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opa <= 32'd0;
            r_opb <= 32'd0;
            r_op  <= 3'd0;
        end else if (w_wr) begin
            case (w_idx)
                3'd0:    r_opa <= apb.pwdata;
                3'd1:    r_opb <= apb.pwdata;
                3'd2:    r_op  <= apb.pwdata[2:0];
                default: ;
            endcase
        end
    end

    // ---------------- Compute engine FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_eng_state <= E_IDLE;
        else       r_eng_state <= w_eng_next;
    end

    always_comb begin
        w_eng_next = r_eng_state;
        case (r_eng_state)
            E_IDLE, E_DONE: if (w_start)  w_eng_next = E_RUN;
            E_RUN:          if (w_finish) w_eng_next = E_DONE;
            default:        w_eng_next = E_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_eng_state == E_RUN);
        w_done = (r_eng_state == E_DONE);
    end

    assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff     = {1'b0, r_a} - {1'b0, r_b};
    assign w_step_sum = {1'b0, r_prod[63:32]} + {1'b0, r_a};
    assign w_is_arith = (r_eop == OP_ADD) || (r_eop == OP_SUB);

    always_comb begin
        w_alu_res = 64'd0;
        case (r_eop)
            OP_ADD:  w_alu_res = {31'd0, w_sum};
            OP_SUB:  w_alu_res = {31'd0, w_diff};
            OP_AND:  w_alu_res = {32'd0, r_a & r_b};
            OP_OR:   w_alu_res = {32'd0, r_a | r_b};
            OP_XOR:  w_alu_res = {32'd0, r_a ^ r_b};
            OP_SHL:  w_alu_res = {32'd0, r_a << r_b[4:0]};
            OP_SHR:  w_alu_res = {32'd0, r_a >> r_b[4:0]};
            default: w_alu_res = r_prod;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_eop   <= 3'd0;
            r_prod  <= 64'd0;
            r_cnt   <= 6'd0;
            r_res   <= 64'd0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_start) begin
            r_a    <= r_opa;
            r_b    <= r_opb;
            r_eop  <= apb.pwdata[2:0];
            r_prod <= {32'd0, r_opb};
            r_cnt  <= 6'd0;
        end else if (w_finish) begin
            r_res   <= w_alu_res;
            r_carry <= w_is_arith && w_alu_res[32];
            // The ADD/SUB carry lives in RES_HI but is a flag, not part of the magnitude.
            r_zero  <= w_is_arith ? (w_alu_res[31:0] == 32'd0) : (w_alu_res == 64'd0);
        end else if (r_eng_state == E_RUN) begin
            r_prod <= r_prod[0] ? {w_step_sum, r_prod[31:1]} : {1'b0, r_prod[63:1]};
            r_cnt  <= r_cnt + 6'd1;
        end
    end
endmodule

// File: tb/tb_alu_apb_slave.sv
// Directed bench for alu_apb_slave: two instances (default stall limit and limit 8) on a shared APB driver.
module tb_alu_apb_slave;
    localparam logic [31:0] A_OPA = 32'h00, A_OPB = 32'h04, A_CTRL = 32'h08;
    localparam logic [31:0] A_STAT = 32'h0C, A_RLO = 32'h10, A_RHI = 32'h14;

    logic        clk;
    logic        reset;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic        tgt;
    logic        b_pready, b_pslverr;
    logic [31:0] b_prdata;
    int          n_checks;
    int          n_errors;

    alu_apb_slave_if apb0();
    alu_apb_slave_if apb1();

    assign apb0.psel    = psel & ~tgt;
    assign apb1.psel    = psel & tgt;
    assign apb0.penable = penable;
    assign apb1.penable = penable;
    assign apb0.pwrite  = pwrite;
    assign apb1.pwrite  = pwrite;
    assign apb0.paddr   = paddr;
    assign apb1.paddr   = paddr;
    assign apb0.pwdata  = pwdata;
    assign apb1.pwdata  = pwdata;

    assign b_pready  = tgt ? apb1.pready  : apb0.pready;
    assign b_pslverr = tgt ? apb1.pslverr : apb0.pslverr;
    assign b_prdata  = tgt ? apb1.prdata  : apb0.prdata;

    alu_apb_slave #(.STALL_LIMIT(40)) u_dut0 (.clk(clk), .reset(reset), .apb(apb0));
    alu_apb_slave #(.STALL_LIMIT(8))  u_dut1 (.clk(clk), .reset(reset), .apb(apb1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Starts right after a rising edge; returns one step after the completing edge.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int waits);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        waits   = 0;
        forever begin
            @(negedge clk);
            if (b_pready) break;
            waits++;
            if (waits > 100) begin
                check("xfer_timeout", 64'(b_pready), 64'd1);
                break;
            end
        end
        rdata = b_prdata;
        err   = b_pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr_chk(input logic [31:0] addr, input logic [31:0] data,
                          input logic exp_err, input string tag);
        logic [31:0] d;
        logic        e;
        int          w;
        xfer(1'b1, addr, data, d, e, w);
        check({tag, "_err"},   64'(e), 64'(exp_err));
        check({tag, "_rdata"}, 64'(d), 64'd0);
        check({tag, "_waits"}, 64'(w), 64'd0);
    endtask

    task automatic rd_chk(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        logic        e;
        int          w;
        xfer(1'b0, addr, 32'd0, d, e, w);
        check(tag,             64'(d), 64'(exp));
        check({tag, "_err"},   64'(e), 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] op_exp [5];

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          w;

        n_checks = 0; n_errors = 0;
        reset = 1'b1; tgt = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0;
        op_exp = '{32'h00F0_0004, 32'hFFF0_1234, 32'hFF00_1230, 32'h0F01_2340, 32'h0F0F_0123};

        repeat (3) @(posedge clk);
        #1;
        check("rst_pready",  64'(apb0.pready),  64'd0);
        check("rst_pslverr", 64'(apb0.pslverr), 64'd0);
        check("rst_prdata",  64'(apb0.prdata),  64'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) rd_chk(32'(i * 4), 32'd0, $sformatf("rst_reg%0d", i));

        // ADD with carry out; zero flag reflects the 32-bit sum
        wr_chk(A_OPA,  32'hFFFF_FFFF, 1'b0, "add_opa");
        wr_chk(A_OPB,  32'h0000_0001, 1'b0, "add_opb");
        wr_chk(A_CTRL, 32'h0000_0100, 1'b0, "add_ctrl");
        rd_chk(A_STAT, 32'h0000_000E, "add_status");
        rd_chk(A_RLO,  32'h0000_0000, "add_reslo");
        rd_chk(A_RHI,  32'h0000_0001, "add_reshi");
        rd_chk(A_CTRL, 32'h0000_0000, "add_ctrl_rd");

        // SUB with borrow
        wr_chk(A_OPA,  32'd3, 1'b0, "sub_opa");
        wr_chk(A_OPB,  32'd5, 1'b0, "sub_opb");
        wr_chk(A_CTRL, 32'h0000_0101, 1'b0, "sub_ctrl");
        rd_chk(A_RLO,  32'hFFFF_FFFE, "sub_reslo");
        rd_chk(A_RHI,  32'h0000_0001, "sub_reshi");
        rd_chk(A_STAT, 32'h0000_0006, "sub_status");

        // Logic and shift ops, back-to-back starts from DONE
        wr_chk(A_OPA, 32'hF0F0_1234, 1'b0, "lg_opa");
        wr_chk(A_OPB, 32'h0FF0_0004, 1'b0, "lg_opb");
        for (int i = 0; i < 5; i++) begin
            wr_chk(A_CTRL, 32'h100 | 32'(i + 2), 1'b0, $sformatf("op%0d_ctrl", i + 2));
            rd_chk(A_RLO,  op_exp[i],     $sformatf("op%0d_reslo", i + 2));
            rd_chk(A_RHI,  32'd0,         $sformatf("op%0d_reshi", i + 2));
            rd_chk(A_STAT, 32'h0000_0002, $sformatf("op%0d_status", i + 2));
        end

        // MUL with an immediate RES_HI read that must stall until completion
        wr_chk(A_OPA,  32'h0001_0000, 1'b0, "mul_opa");
        wr_chk(A_OPB,  32'h0001_0000, 1'b0, "mul_opb");
        wr_chk(A_CTRL, 32'h0000_0107, 1'b0, "mul_ctrl");
        xfer(1'b0, A_RHI, 32'd0, d, e, w);
        check("mul_waits_in_range", 64'(w >= 32 && w <= 33), 64'd1);
        check("mul_reshi", 64'(d), 64'd1);
        check("mul_err",   64'(e), 64'd0);
        rd_chk(A_RLO,  32'd0,         "mul_reslo");
        rd_chk(A_STAT, 32'h0000_0002, "mul_status");

        // Writes while busy are rejected and the product uses the original operand
        wr_chk(A_OPA,  32'h0000_1234, 1'b0, "busy_opa");
        wr_chk(A_OPB,  32'h0000_0100, 1'b0, "busy_opb");
        wr_chk(A_CTRL, 32'h0000_0107, 1'b0, "busy_ctrl");
        rd_chk(A_STAT, 32'h0000_0001, "busy_status");
        wr_chk(A_OPA,  32'd5,         1'b1, "busy_wr_opa");
        wr_chk(A_CTRL, 32'h0000_0100, 1'b1, "busy_wr_ctrl");
        rd_chk(A_RLO,  32'h0012_3400, "busy_reslo");
        rd_chk(A_RHI,  32'd0,         "busy_reshi");
        rd_chk(A_OPA,  32'h0000_1234, "busy_opa_kept");
        rd_chk(A_CTRL, 32'h0000_0007, "busy_ctrl_kept");

        // Decode errors and read-only targets
        xfer(1'b0, 32'h18, 32'd0, d, e, w);
        check("bad18_err",   64'(e), 64'd1);
        check("bad18_rdata", 64'(d), 64'd0);
        check("bad18_waits", 64'(w), 64'd0);
        xfer(1'b0, 32'h0000_0020, 32'd0, d, e, w);
        check("hiaddr_err",   64'(e), 64'd1);
        check("hiaddr_rdata", 64'(d), 64'd0);
        wr_chk(A_RLO,  32'hDEAD_BEEF, 1'b1, "ro_reslo_wr");
        wr_chk(A_STAT, 32'hFFFF_FFFF, 1'b1, "ro_status_wr");
        rd_chk(A_RLO,  32'h0012_3400, "ro_reslo_kept");
        rd_chk(A_STAT, 32'h0000_0002, "ro_status_kept");
        rd_chk(32'h01, 32'h0000_1234, "lowbits_ignored");

        // Stall limit of 8 on the second instance
        tgt = 1'b1;
        wr_chk(A_OPA,  32'hFFFF_FFFF, 1'b0, "sl_opa");
        wr_chk(A_OPB,  32'hFFFF_FFFF, 1'b0, "sl_opb");
        wr_chk(A_CTRL, 32'h0000_0107, 1'b0, "sl_ctrl");
        xfer(1'b0, A_RLO, 32'd0, d, e, w);
        check("sl_waits", 64'(w), 64'd8);
        check("sl_err",   64'(e), 64'd1);
        check("sl_rdata", 64'(d), 64'd0);
        idle(40);
        rd_chk(A_RLO,  32'h0000_0001, "sl_reslo");
        rd_chk(A_RHI,  32'hFFFF_FFFE, "sl_reshi");
        rd_chk(A_STAT, 32'h0000_0002, "sl_status");
        tgt = 1'b0;

        // Reset in the middle of a MUL while a read is completing
        wr_chk(A_OPA,  32'd7, 1'b0, "rm_opa");
        wr_chk(A_OPB,  32'd9, 1'b0, "rm_opb");
        wr_chk(A_CTRL, 32'h0000_0107, 1'b0, "rm_ctrl");
        idle(10);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_OPA;
        @(posedge clk); #1;
        penable = 1'b1;
        #2;
        check("rm_pre_pready", 64'(apb0.pready), 64'd1);
        check("rm_pre_prdata", 64'(apb0.prdata), 64'd7);
        reset = 1'b1;
        #1;
        check("rm_pready",  64'(apb0.pready),  64'd0);
        check("rm_prdata",  64'(apb0.prdata),  64'd0);
        check("rm_pslverr", 64'(apb0.pslverr), 64'd0);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        rd_chk(A_STAT, 32'd0, "rm_status");
        rd_chk(A_OPA,  32'd0, "rm_opa_clr");
        rd_chk(A_RLO,  32'd0, "rm_reslo_clr");
        wr_chk(A_OPA,  32'd2, 1'b0, "post_opa");
        wr_chk(A_OPB,  32'd3, 1'b0, "post_opb");
        wr_chk(A_CTRL, 32'h0000_0100, 1'b0, "post_ctrl");
        rd_chk(A_RLO,  32'd5, "post_reslo");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
